// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic SRC_INST = 1'b0;
   localparam logic SRC_DATA = 1'b1;

   localparam int unsigned MASK_W = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational source selection between fetch and load/store requests.
// MEM_BUS_ARBITER_RR_EN: when defined, simultaneous requests alternate
// against last_grant; otherwise data always beats instruction.
module mem_arb_pick
   import mem_bus_arbiter_pkg::*;
(
   input  logic inst_req,
   input  logic data_req,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_src
);

`ifdef MEM_BUS_ARBITER_RR_EN
   // Round-robin: on a tie the source not granted last time wins
   always_comb begin
      grant_valid = inst_req | data_req;
      grant_src   = SRC_DATA;
      if (inst_req && data_req) begin
         grant_src = (last_grant == SRC_DATA) ? SRC_INST : SRC_DATA;
      end else if (inst_req) begin
         grant_src = SRC_INST;
      end
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   // Fixed priority: data port beats instruction fetch
   always_comb begin
      grant_valid = inst_req | data_req;
      grant_src   = SRC_DATA;
      if (inst_req && !data_req) begin
         grant_src = SRC_INST;
      end
   end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and load/store ports.
// Single outstanding transaction: IDLE -> REQ -> WAIT -> RESP -> IDLE.
// MEM_BUS_ARBITER_RR_EN: adds a last-grant register for round-robin ties.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned INST_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inst_addr_valid_i,
   input  logic [ADDR_WIDTH-1:0] inst_addr_i,
   output logic                  inst_valid_o,
   output logic [INST_WIDTH-1:0] inst_o,
   input  logic                  data_r_en_i,
   input  logic                  data_w_en_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic [DATA_WIDTH-1:0] data_w_i,
   input  logic [MASK_W-1:0]     data_w_mask_i,
   output logic                  data_r_valid_o,
   output logic [DATA_WIDTH-1:0] data_r_o,
   output logic                  data_w_ready_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic [MASK_W-1:0]     mem_wmask_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_resp_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   state_t state;
   logic   src;
   logic   last_grant;
   logic   grant_valid;
   logic   grant_src;

   mem_arb_pick u_pick (
      .inst_req    (inst_addr_valid_i),
      .data_req    (data_r_en_i | data_w_en_i),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_src   (grant_src)
   );

`ifdef MEM_BUS_ARBITER_RR_EN
   // Remember which source was granted on every issue
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= SRC_DATA;
      end else if (state == IDLE && grant_valid) begin
         last_grant <= grant_src;
      end
   end
`else
   assign last_grant = SRC_DATA;
`endif

   // Transaction sequencer; mem_* come straight from the latched request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         src            <= SRC_INST;
         inst_valid_o   <= 1'b0;
         inst_o         <= '0;
         data_r_valid_o <= 1'b0;
         data_r_o       <= '0;
         data_w_ready_o <= 1'b0;
         mem_req_o      <= 1'b0;
         mem_we_o       <= 1'b0;
         mem_addr_o     <= '0;
         mem_wdata_o    <= '0;
         mem_wmask_o    <= '0;
      end else begin
         inst_valid_o   <= 1'b0;
         data_r_valid_o <= 1'b0;
         data_w_ready_o <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  state     <= REQ;
                  mem_req_o <= 1'b1;
                  src       <= grant_src;
                  if (grant_src == SRC_DATA) begin
                     // A store wins over a simultaneous (illegal) load
                     mem_we_o    <= data_w_en_i;
                     mem_addr_o  <= data_addr_i;
                     mem_wdata_o <= data_w_en_i ? data_w_i : '0;
                     mem_wmask_o <= data_w_en_i ? data_w_mask_i : '0;
                  end else begin
                     mem_we_o    <= 1'b0;
                     mem_addr_o  <= {inst_addr_i[ADDR_WIDTH-1:2], 2'b00};
                     mem_wdata_o <= '0;
                     mem_wmask_o <= '0;
                  end
               end
            end
            REQ: begin
               if (mem_gnt_i) begin
                  state     <= WAIT;
                  mem_req_o <= 1'b0;
               end
            end
            WAIT: begin
               if (mem_resp_i) begin
                  state <= RESP;
                  if (src == SRC_INST) begin
                     inst_valid_o <= 1'b1;
                     inst_o <= mem_addr_o[2] ? mem_rdata_i[2*INST_WIDTH-1:INST_WIDTH]
                                             : mem_rdata_i[INST_WIDTH-1:0];
                  end else if (mem_we_o) begin
                     data_w_ready_o <= 1'b1;
                  end else begin
                     data_r_valid_o <= 1'b1;
                     data_r_o       <= mem_rdata_i;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   // Flag a load and a store presented together while sampling
   always @(posedge clk) begin
      if (!rst && state == IDLE) begin
         assert (!(data_r_en_i && data_w_en_i))
            else $warning("mem_bus_arbiter: simultaneous load and store, store issued");
      end
   end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (default build).
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_addr_valid_i;
   logic [63:0] inst_addr_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic        data_r_en_i;
   logic        data_w_en_i;
   logic [63:0] data_addr_i;
   logic [63:0] data_w_i;
   logic [7:0]  data_w_mask_i;
   logic        data_r_valid_o;
   logic [63:0] data_r_o;
   logic        data_w_ready_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [63:0] mem_addr_o;
   logic [63:0] mem_wdata_o;
   logic [7:0]  mem_wmask_o;
   logic        mem_gnt_i;
   logic        mem_resp_i;
   logic [63:0] mem_rdata_i;

   int checks = 0;
   int errors = 0;
   int gnt_cnt = 0;
   int snap;

   mem_bus_arbiter dut (
      .clk               (clk),
      .rst               (rst),
      .inst_addr_valid_i (inst_addr_valid_i),
      .inst_addr_i       (inst_addr_i),
      .inst_valid_o      (inst_valid_o),
      .inst_o            (inst_o),
      .data_r_en_i       (data_r_en_i),
      .data_w_en_i       (data_w_en_i),
      .data_addr_i       (data_addr_i),
      .data_w_i          (data_w_i),
      .data_w_mask_i     (data_w_mask_i),
      .data_r_valid_o    (data_r_valid_o),
      .data_r_o          (data_r_o),
      .data_w_ready_o    (data_w_ready_o),
      .mem_req_o         (mem_req_o),
      .mem_we_o          (mem_we_o),
      .mem_addr_o        (mem_addr_o),
      .mem_wdata_o       (mem_wdata_o),
      .mem_wmask_o       (mem_wmask_o),
      .mem_gnt_i         (mem_gnt_i),
      .mem_resp_i        (mem_resp_i),
      .mem_rdata_i       (mem_rdata_i)
   );

   always #5 clk = ~clk;

   // Count accepted memory transactions
   always @(posedge clk) begin
      if (!rst && mem_req_o && mem_gnt_i) gnt_cnt <= gnt_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   initial begin
      rst = 1'b1;
      inst_addr_valid_i = 1'b0; inst_addr_i = '0;
      data_r_en_i = 1'b0; data_w_en_i = 1'b0; data_addr_i = '0;
      data_w_i = '0; data_w_mask_i = '0;
      mem_gnt_i = 1'b0; mem_resp_i = 1'b0; mem_rdata_i = '0;
      #1;
      chk("rst_mem_req", 64'(mem_req_o), 64'd0);
      chk("rst_inst_valid", 64'(inst_valid_o), 64'd0);
      chk("rst_mem_addr", mem_addr_o, 64'd0);
      chk("rst_data_r", data_r_o, 64'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Fetch only: high word selected by addr[2]
      inst_addr_valid_i = 1'b1; inst_addr_i = 64'h8000_0004;
      tick();
      chk("f1_req", 64'(mem_req_o), 64'd1);
      chk("f1_addr", mem_addr_o, 64'h8000_0004);
      chk("f1_we", 64'(mem_we_o), 64'd0);
      chk("f1_no_early_valid", 64'(inst_valid_o), 64'd0);
      mem_gnt_i = 1'b1;
      tick();
      chk("f1_req_drop", 64'(mem_req_o), 64'd0);
      mem_gnt_i = 1'b0; mem_resp_i = 1'b1; mem_rdata_i = 64'h1111_2222_3333_4444;
      tick();
      chk("f1_valid", 64'(inst_valid_o), 64'd1);
      chk("f1_inst", 64'(inst_o), 64'h1111_2222);
      mem_resp_i = 1'b0; inst_addr_valid_i = 1'b0;
      tick();
      chk("f1_pulse_once", 64'(inst_valid_o), 64'd0);
      chk("f1_inst_hold", 64'(inst_o), 64'h1111_2222);
      chk("f1_idle_no_req", 64'(mem_req_o), 64'd0);

      // Load vs fetch in the same cycle: load first
      inst_addr_valid_i = 1'b1; inst_addr_i = 64'h8000_0000;
      data_r_en_i = 1'b1; data_addr_i = 64'h8000_0100;
      tick();
      chk("lf_req", 64'(mem_req_o), 64'd1);
      chk("lf_we", 64'(mem_we_o), 64'd0);
      chk("lf_addr_load", mem_addr_o, 64'h8000_0100);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0; mem_resp_i = 1'b1; mem_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
      tick();
      chk("lf_rvalid", 64'(data_r_valid_o), 64'd1);
      chk("lf_rdata", data_r_o, 64'hAAAA_BBBB_CCCC_DDDD);
      chk("lf_no_ivalid", 64'(inst_valid_o), 64'd0);
      mem_resp_i = 1'b0; data_r_en_i = 1'b0;
      tick();
      chk("lf_rvalid_drop", 64'(data_r_valid_o), 64'd0);
      chk("lf_idle_gap", 64'(mem_req_o), 64'd0);
      tick();
      chk("lf_fetch_req", 64'(mem_req_o), 64'd1);
      chk("lf_fetch_addr", mem_addr_o, 64'h8000_0000);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0; mem_resp_i = 1'b1; mem_rdata_i = 64'h5555_6666_7777_8888;
      tick();
      chk("lf_ivalid", 64'(inst_valid_o), 64'd1);
      chk("lf_inst_low", 64'(inst_o), 64'h7777_8888);
      chk("lf_rdata_hold", data_r_o, 64'hAAAA_BBBB_CCCC_DDDD);
      mem_resp_i = 1'b0; inst_addr_valid_i = 1'b0;
      tick();

      // Store with a three-cycle grant stall; inputs wiggle, bus must not
      data_w_en_i = 1'b1; data_addr_i = 64'h8000_0200;
      data_w_i = 64'hDEAD_BEEF_0000_0001; data_w_mask_i = 8'h0F;
      tick();
      data_w_i = 64'h0; data_addr_i = 64'h0; data_w_mask_i = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         chk("st_stall_req", 64'(mem_req_o), 64'd1);
         chk("st_stall_we", 64'(mem_we_o), 64'd1);
         chk("st_stall_addr", mem_addr_o, 64'h8000_0200);
         chk("st_stall_wdata", mem_wdata_o, 64'hDEAD_BEEF_0000_0001);
         chk("st_stall_mask", 64'(mem_wmask_o), 64'h0F);
         tick();
      end
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      tick();
      chk("st_wait_no_ready", 64'(data_w_ready_o), 64'd0);
      mem_resp_i = 1'b1;
      tick();
      chk("st_ready", 64'(data_w_ready_o), 64'd1);
      chk("st_no_rvalid", 64'(data_r_valid_o), 64'd0);
      mem_resp_i = 1'b0; data_w_en_i = 1'b0;
      tick();
      chk("st_ready_once", 64'(data_w_ready_o), 64'd0);

      // Back-to-back fetches: low half then high half, two transactions
      snap = gnt_cnt;
      inst_addr_valid_i = 1'b1; inst_addr_i = 64'h8000_0000;
      tick();
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0; mem_resp_i = 1'b1; mem_rdata_i = 64'h0123_4567_89AB_CDEF;
      tick();
      chk("bb_first_valid", 64'(inst_valid_o), 64'd1);
      chk("bb_first_inst", 64'(inst_o), 64'h89AB_CDEF);
      mem_resp_i = 1'b0; inst_addr_i = 64'h8000_0004;
      tick();
      chk("bb_gap_req", 64'(mem_req_o), 64'd0);
      tick();
      chk("bb_second_addr", mem_addr_o, 64'h8000_0004);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0; mem_resp_i = 1'b1;
      tick();
      chk("bb_second_valid", 64'(inst_valid_o), 64'd1);
      chk("bb_second_inst", 64'(inst_o), 64'h0123_4567);
      mem_resp_i = 1'b0; inst_addr_valid_i = 1'b0;
      tick(); tick();
      chk("bb_txn_count", 64'(gnt_cnt - snap), 64'd2);

      // Async reset while waiting for the response
      inst_addr_valid_i = 1'b1; inst_addr_i = 64'h8000_0008;
      tick();
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      #2;
      rst = 1'b1; inst_addr_valid_i = 1'b0;
      #1;
      chk("ar_mem_req", 64'(mem_req_o), 64'd0);
      chk("ar_mem_addr", mem_addr_o, 64'd0);
      chk("ar_inst", 64'(inst_o), 64'd0);
      chk("ar_data_r", data_r_o, 64'd0);
      tick();
      rst = 1'b0; mem_resp_i = 1'b1; mem_rdata_i = 64'hFFFF_EEEE_DDDD_CCCC;
      tick();
      chk("ar_no_pulse", 64'(inst_valid_o), 64'd0);
      mem_resp_i = 1'b0;
      tick();
      chk("ar_no_pulse2", 64'(inst_valid_o), 64'd0);
      inst_addr_valid_i = 1'b1; inst_addr_i = 64'h8000_0004;
      tick();
      chk("ar_refetch_req", 64'(mem_req_o), 64'd1);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0; mem_resp_i = 1'b1; mem_rdata_i = 64'hCAFE_F00D_1234_5678;
      tick();
      chk("ar_refetch_valid", 64'(inst_valid_o), 64'd1);
      chk("ar_refetch_inst", 64'(inst_o), 64'hCAFE_F00D);
      mem_resp_i = 1'b0; inst_addr_valid_i = 1'b0;
      tick();

      // Store with zero mask is still issued
      data_w_en_i = 1'b1; data_addr_i = 64'h8000_0400;
      data_w_i = 64'h0000_0000_0000_00AA; data_w_mask_i = 8'h00;
      tick();
      chk("m0_req", 64'(mem_req_o), 64'd1);
      chk("m0_we", 64'(mem_we_o), 64'd1);
      chk("m0_mask", 64'(mem_wmask_o), 64'h00);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0; mem_resp_i = 1'b1;
      tick();
      chk("m0_ready", 64'(data_w_ready_o), 64'd1);
      mem_resp_i = 1'b0; data_w_en_i = 1'b0;
      tick();

      // Illegal load+store: write is issued
      data_r_en_i = 1'b1; data_w_en_i = 1'b1; data_addr_i = 64'h8000_0300;
      data_w_i = 64'h0000_0000_0000_0001; data_w_mask_i = 8'hFF;
      tick();
      chk("ls_we", 64'(mem_we_o), 64'd1);
      chk("ls_mask", 64'(mem_wmask_o), 64'hFF);
      chk("ls_wdata", mem_wdata_o, 64'h1);
      data_r_en_i = 1'b0;
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0; mem_resp_i = 1'b1; mem_rdata_i = 64'h9999_9999_9999_9999;
      tick();
      chk("ls_ready", 64'(data_w_ready_o), 64'd1);
      chk("ls_no_rvalid", 64'(data_r_valid_o), 64'd0);
      chk("ls_rdata_hold", data_r_o, 64'd0);
      mem_resp_i = 1'b0; data_w_en_i = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one 64-bit memory bus between the core's instruction-fetch port and its load/store data port.
- Single outstanding transaction; FSM-sequenced request/grant/response handshake toward memory.
- Returns a one-cycle `valid`/`ready` pulse to the winning core port.
- Sits between the RISC-V core top and the memory model / SoC bus bridge.

Parameters:
- ADDR_WIDTH, 64, memory address width (instruction and data).
- DATA_WIDTH, 64, memory and data-port data width.
- INST_WIDTH, 32, instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- inst_addr_valid_i  in  1  fetch request, held until inst_valid_o
- inst_addr_i  in  ADDR_WIDTH  fetch address
- inst_valid_o  out  1  one-cycle pulse: inst_o valid
- inst_o  out  INST_WIDTH  fetched instruction
- data_r_en_i  in  1  load request, held until data_r_valid_o
- data_w_en_i  in  1  store request, held until data_w_ready_o
- data_addr_i  in  ADDR_WIDTH  load/store address
- data_w_i  in  DATA_WIDTH  store data
- data_w_mask_i  in  8  store byte mask
- data_r_valid_o  out  1  one-cycle pulse: data_r_o valid
- data_r_o  out  DATA_WIDTH  load data
- data_w_ready_o  out  1  one-cycle pulse: store complete
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  write data
- mem_wmask_o  out  8  write byte mask
- mem_gnt_i  in  1  memory accepted request this cycle
- mem_resp_i  in  1  read data valid / write done
- mem_rdata_i  in  DATA_WIDTH  read data

Behaviour:
- Clock and reset: single clock `clk`; `rst` asynchronous, active-high.
- Reset values: every output is 0; FSM in IDLE; latched request registers are 0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Sample requests.
  - Pick source: data beats instruction (fixed priority).
  - Latch source id, address, we, wdata and wmask; go to REQ.
  - No request: stay in IDLE.
- REQ:
  - mem_req_o = 1; mem_* are driven from the latched registers only.
  - On mem_gnt_i go to WAIT; otherwise hold all mem_* stable.
- WAIT:
  - mem_req_o = 0.
  - On mem_resp_i, capture mem_rdata_i into the response register and go to RESP.
  - mem_resp_i in the same cycle as mem_gnt_i (REQ state) is ignored; memory must respond no earlier than the cycle after grant.
- RESP (exactly one cycle, then IDLE):
  - Instruction source: inst_valid_o = 1; inst_o = captured[63:32] if latched addr[2] = 1, else captured[31:0].
  - Load: data_r_valid_o = 1; data_r_o = captured data.
  - Store: data_w_ready_o = 1.
  - inst_o and data_r_o hold their last value outside RESP.
- Latency:
  - Request seen in IDLE at cycle 0; mem_req_o high at cycle 1.
  - With gnt at cycle 1 and resp at cycle 2, the response pulse is at cycle 3.
  - Minimum 4 cycles per transaction, including the IDLE sampling cycle.
- The requester changes or drops its request on the edge after the response pulse; IDLE re-samples on that cycle, so there is no duplicate issue.
- Simultaneous load and store (data_r_en_i & data_w_en_i) is illegal: write wins, and a simulation-only assertion fires.
- Store with mask 0 is issued normally.
- Inst address bits [1:0] are ignored; bit 2 selects the word.
- Requests dropped while in REQ/WAIT do not abort the transaction; the response pulse is still produced.
- Reset mid-transaction: immediate return to IDLE, no response pulse. The memory side shares `rst`, so the in-flight transaction is abandoned.

Optional Feature:
- Macro: MEM_BUS_ARBITER_RR_EN.
- Defined:
  - A last-grant register (reset = data) is added.
  - When both sources request in IDLE, the source not granted last wins.
  - The register updates on every IDLE->REQ transition.
- Undefined: fixed data-over-instruction priority; no extra register.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=0, REQ=1, WAIT=2, RESP=3).
  - Source id constants (SRC_INST=0, SRC_DATA=1).
  - Mask width constant 8.
- One sub-module: mem_arb_pick.
  - Combinational source selection: fixed priority, or round-robin under the macro.
  - Inputs: inst_req, data_req, last_grant.
  - Outputs: grant_valid, grant_src.

Test Plan:
- Fetch only: addr 0x8000_0004, gnt immediate, resp next cycle with rdata 0x1111_2222_3333_4444 -> inst_o = 0x1111_2222, inst_valid_o pulses once, 3 cycles after request.
- Load vs fetch in the same cycle, addresses 0x8000_0100 / 0x8000_0000 -> load issued first (mem_we_o=0, addr 0x100); fetch issued only after data_r_valid_o. With RR_EN defined and last grant = data -> fetch first.
- Store: addr 0x8000_0200, data 0xDEAD_BEEF_0000_0001, mask 0x0F, gnt delayed 3 cycles -> mem_* stable through the stall, mem_wmask_o = 0x0F, data_w_ready_o pulses once after resp.
- Back-to-back fetches 0x8000_0000 then 0x8000_0004 -> exactly two mem_req_o transactions, no duplicate, inst words low then high half.
- Async rst asserted in WAIT -> all outputs 0 without a clock edge; the later mem_resp_i produces no pulse; the next fetch completes normally.
- Load and store both asserted -> write issued, assertion flagged.
